// File: rtl/genome_pkg.sv
// Shared genome-path definitions: ASCII codes for bases, the 2-bit base code
// type, the decoder FSM state type and the base-to-ASCII mapping.
package genome_pkg;

  localparam logic [7:0] ASCII_A = 8'h41;
  localparam logic [7:0] ASCII_C = 8'h43;
  localparam logic [7:0] ASCII_G = 8'h47;
  localparam logic [7:0] ASCII_T = 8'h54;
  localparam logic [7:0] ASCII_N = 8'h4E;

  typedef enum logic [1:0] {
    BaseA = 2'b00,
    BaseC = 2'b01,
    BaseG = 2'b10,
    BaseT = 2'b11
  } base_code_t;

  typedef enum logic [0:0] {
    StEmpty,
    StDrain
  } dec_state_e;

  function automatic logic [7:0] base2ascii(base_code_t code);
    logic [7:0] c;
    c = ASCII_A;
    unique case (code)
      BaseA: c = ASCII_A;
      BaseC: c = ASCII_C;
      BaseG: c = ASCII_G;
      BaseT: c = ASCII_T;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/base_lane_decode.sv
// Combinational decode of one output beat: OUT_BASES 2-bit codes to ASCII,
// N-masked bases forced to 'N', unkept characters forced to 0x00.
module base_lane_decode
  import genome_pkg::*;
#(
  parameter int unsigned OUT_BASES = 4
) (
  input  logic [2*OUT_BASES-1:0] codes_i,
  input  logic [OUT_BASES-1:0]   nmask_i,
  input  logic [OUT_BASES-1:0]   keep_i,
  output logic [8*OUT_BASES-1:0] data_o
);

  // Per-character mapping; padding characters past the word end read as zero.
  always_comb begin
    data_o = '0;
    for (int unsigned j = 0; j < OUT_BASES; j++) begin
      if (keep_i[j]) begin
        data_o[8*j +: 8] = nmask_i[j] ? ASCII_N : base2ascii(base_code_t'(codes_i[2*j +: 2]));
      end
    end
  end

endmodule

// File: rtl/packed_base_stream_decoder.sv
// Packed 2-bit nucleotide word to ASCII beat stream. A word is held and
// drained OUT_BASES characters per beat; the final beat may be partial.
// Optional macro BASE_NMASK_EN adds the in_nmask_i port and per-base 'N' decode.
module packed_base_stream_decoder
  import genome_pkg::*;
#(
  parameter int unsigned IN_BASES  = 16,
  parameter int unsigned OUT_BASES = 4,
  parameter int unsigned CNT_W     = $clog2(IN_BASES + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [2*IN_BASES-1:0]  in_data_i,
  input  logic [CNT_W-1:0]       in_count_i,
  input  logic                   in_last_i,
`ifdef BASE_NMASK_EN
  input  logic [IN_BASES-1:0]    in_nmask_i,
`endif
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [8*OUT_BASES-1:0] out_data_o,
  output logic [OUT_BASES-1:0]   out_keep_o,
  output logic                   out_last_o
);

  localparam int unsigned MaxBeats = IN_BASES / OUT_BASES;
  localparam int unsigned BeatW    = (MaxBeats > 1) ? $clog2(MaxBeats) : 1;

  dec_state_e             state_q;
  logic [2*IN_BASES-1:0]  data_q;
  logic [CNT_W-1:0]       count_q;
  logic                   last_q;
  logic [BeatW-1:0]       beat_q;
  logic                   out_valid_q;
  logic [8*OUT_BASES-1:0] out_data_q;
  logic [OUT_BASES-1:0]   out_keep_q;
  logic                   out_last_q;

  logic [IN_BASES-1:0]    nmask_in;
  logic [IN_BASES-1:0]    nmask_held;
  logic                   is_final;
  logic                   out_hs;
  logic                   in_hs;
  logic                   advance;
  logic [CNT_W-1:0]       norm_count;

  logic [2*IN_BASES-1:0]  src_data;
  logic [IN_BASES-1:0]    src_nmask;
  logic [CNT_W-1:0]       src_count;
  logic                   src_last;
  logic [BeatW-1:0]       src_beat;
  logic [31:0]            src_rem;
  logic [OUT_BASES-1:0]   src_keep;
  logic                   src_final;
  logic [8*OUT_BASES-1:0] lane_data;

  logic [MaxBeats-1:0][2*OUT_BASES-1:0] src_codes_all;
  logic [MaxBeats-1:0][OUT_BASES-1:0]   src_nmask_all;

`ifdef BASE_NMASK_EN
  logic [IN_BASES-1:0] nmask_q;
  assign nmask_in   = in_nmask_i;
  assign nmask_held = nmask_q;

  // The N mask is captured together with the word it qualifies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nmask_q <= '0;
    end else if (in_hs) begin
      nmask_q <= in_nmask_i;
    end
  end
`else
  assign nmask_in   = '0;
  assign nmask_held = '0;
`endif

  // Zero and oversize counts both mean a full word.
  assign norm_count = ((in_count_i == '0) || (32'(in_count_i) > IN_BASES)) ?
                      CNT_W'(IN_BASES) : in_count_i;

  assign is_final   = ((32'(beat_q) + 32'd1) * OUT_BASES) >= 32'(count_q);
  assign out_hs     = out_valid_q & out_ready_i;
  // Ready follows out_ready_i only while the final beat is leaving.
  assign in_ready_o = (state_q == StEmpty) | (out_hs & is_final);
  assign in_hs      = in_valid_i & in_ready_o;
  assign advance    = out_hs & ~is_final;

  // Select what the output register loads next: beat 0 of a new word or the
  // following beat of the held word.
  always_comb begin
    src_data  = data_q;
    src_nmask = nmask_held;
    src_count = count_q;
    src_last  = last_q;
    src_beat  = beat_q + 1'b1;
    if (in_hs) begin
      src_data  = in_data_i;
      src_nmask = nmask_in;
      src_count = norm_count;
      src_last  = in_last_i;
      src_beat  = '0;
    end
  end

  assign src_codes_all = src_data;
  assign src_nmask_all = src_nmask;

  // Characters remaining from the selected beat onwards set keep and last.
  always_comb begin
    src_rem  = 32'(src_count) - (32'(src_beat) * OUT_BASES);
    src_keep = '0;
    for (int unsigned j = 0; j < OUT_BASES; j++) begin
      src_keep[j] = (j < src_rem);
    end
  end

  assign src_final = (src_rem <= OUT_BASES);

  base_lane_decode #(
    .OUT_BASES(OUT_BASES)
  ) u_lane (
    .codes_i(src_codes_all[src_beat]),
    .nmask_i(src_nmask_all[src_beat]),
    .keep_i (src_keep),
    .data_o (lane_data)
  );

  // FSM, holding register and registered output beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      data_q      <= '0;
      count_q     <= '0;
      last_q      <= 1'b0;
      beat_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (in_hs) begin
      state_q     <= StDrain;
      data_q      <= in_data_i;
      count_q     <= norm_count;
      last_q      <= in_last_i;
      beat_q      <= '0;
      out_valid_q <= 1'b1;
      out_data_q  <= lane_data;
      out_keep_q  <= src_keep;
      out_last_q  <= src_last & src_final;
    end else if (advance) begin
      beat_q      <= src_beat;
      out_data_q  <= lane_data;
      out_keep_q  <= src_keep;
      out_last_q  <= src_last & src_final;
    end else if (out_hs) begin
      state_q     <= StEmpty;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_keep_o  = out_keep_q;
  assign out_last_o  = out_last_q;

endmodule
